// File: rtl/serial_frame_pkg.sv
// Shared frame definitions for the serial deframer: FSM states, line levels, parity helper.
// The PARITY state exists only when SERIAL_DEFRAMER_PARITY_EN is defined.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd2
`ifdef SERIAL_DEFRAMER_PARITY_EN
    , PARITY = 2'd3
`endif
  } state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  localparam int MAX_W = 16;

  // Even parity holds when payload plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [MAX_W-1:0] payload, input logic par_bit);
    return ~(^{payload, par_bit});
  endfunction

endpackage

// File: rtl/serial_deframer_if.sv
// Bundle of the serial line input and the valid/ready output side of the deframer.
interface serial_deframer_if #(parameter int DATA_W = 8);
  import serial_frame_pkg::*;

  logic              din;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    input  din, out_ready,
    output out_data, out_valid, frame_err, overrun, busy
  );

  modport slave (
    output din, out_ready,
    input  out_data, out_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_deframer_out_buf.sv
// Output holding register for deframed payloads with valid/ready handshake and sticky overrun.
module deframer_out_buf
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clkAB,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              overrun
);

  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              over_r;

  // A new frame wins over the handshake clear; a blocked frame only raises the sticky flag.
  always_ff @(posedge clkAB) begin
    if (rst) begin
      data_r  <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      over_r  <= 1'b0;
    end else if (load) begin
      if (!valid_r || out_ready) begin
        data_r  <= load_data;
        valid_r <= 1'b1;
      end else begin
        over_r  <= 1'b1;
      end
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign overrun   = over_r;

endmodule

// File: rtl/serial_deframer.sv
// Serial deframer: start 1, DATA_W bits LSB first, optional even parity, stop 0.
// Parity stage compiled in with SERIAL_DEFRAMER_PARITY_EN.
module serial_deframer
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic               clkAB,
  input logic               rst,
  serial_deframer_if.master bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [DATA_W-1:0] shreg_r, shreg_nxt_s;
  logic              frame_ok_s, frame_bad_s;
  logic              frame_err_r, busy_r;
  logic [DATA_W-1:0] out_data_s;
  logic              out_valid_s, overrun_s;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic              par_err_r, par_err_nxt_s;
`endif

  // Next-state, shift and frame verdict; the verdict is only produced while sampling the stop bit.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shreg_nxt_s = shreg_r;
    frame_ok_s  = 1'b0;
    frame_bad_s = 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    par_err_nxt_s = par_err_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.din == START_BIT) begin
          state_nxt_s = DATA;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        shreg_nxt_s = {bus.din, shreg_r[DATA_W-1:1]};
        if (cnt_r == LAST_BIT) begin
          cnt_nxt_s = {CNT_W{1'b0}};
`ifdef SERIAL_DEFRAMER_PARITY_EN
          state_nxt_s = PARITY;
`else
          state_nxt_s = STOP;
`endif
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end
      end
`ifdef SERIAL_DEFRAMER_PARITY_EN
      PARITY: begin
        par_err_nxt_s = ~even_parity_ok(MAX_W'(shreg_r), bus.din);
        state_nxt_s   = STOP;
      end
`endif
      STOP: begin
        state_nxt_s = IDLE;
`ifdef SERIAL_DEFRAMER_PARITY_EN
        if ((bus.din == STOP_BIT) && !par_err_r) begin
`else
        if (bus.din == STOP_BIT) begin
`endif
          frame_ok_s = 1'b1;
        end else begin
          frame_bad_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; busy follows the state being entered so it is registered too.
  always_ff @(posedge clkAB) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      shreg_r     <= {DATA_W{1'b0}};
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
      par_err_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      shreg_r     <= shreg_nxt_s;
      frame_err_r <= frame_bad_s;
      busy_r      <= (state_nxt_s != IDLE);
`ifdef SERIAL_DEFRAMER_PARITY_EN
      par_err_r   <= par_err_nxt_s;
`endif
    end
  end

  deframer_out_buf #(.DATA_W(DATA_W)) u_out_buf (
    .clkAB     (clkAB),
    .rst       (rst),
    .load      (frame_ok_s),
    .load_data (shreg_r),
    .out_ready (bus.out_ready),
    .out_data  (out_data_s),
    .out_valid (out_valid_s),
    .overrun   (overrun_s)
  );

  assign bus.out_data  = out_data_s;
  assign bus.out_valid = out_valid_s;
  assign bus.overrun   = overrun_s;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_serial_deframer.sv
// Self-checking bench for serial_deframer: directed table, hand sequences, random traffic vs. a frame-level model.
module tb_serial_deframer;
  import serial_frame_pkg::*;

  localparam int DW = 8;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  localparam int FLEN    = DW + 3;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int FLEN    = DW + 2;
  localparam bit HAS_PAR = 1'b0;
`endif

  logic clkAB = 1'b0;
  logic rst;

  serial_deframer_if #(.DATA_W(DW)) bus ();
  serial_deframer #(.DATA_W(DW)) dut (.clkAB(clkAB), .rst(rst), .bus(bus));

  always #5 clkAB = ~clkAB;

  int checks = 0;
  int errors = 0;
  int first_valid;

  bit          m_in_frame;
  int          m_pos;
  logic        m_bits [0:31];
  logic [DW-1:0] m_data;
  logic        m_valid, m_err, m_over, m_busy;

  typedef struct {
    logic [DW-1:0] payload;
    logic          stop;
    logic          rdy_end;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_err;
    logic          e_over;
  } vec_t;
  vec_t vecs [8];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Frame-level model: track position within a frame, decide the whole frame at its last bit.
  task automatic model_update();
    logic consume, good, par;
    int   payload;
    if (rst) begin
      m_in_frame = 1'b0; m_pos = 0;
      m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_over = 1'b0; m_busy = 1'b0;
    end else begin
      consume = m_valid && bus.out_ready;
      good    = 1'b0;
      m_err   = 1'b0;
      if (!m_in_frame) begin
        if (bus.din === 1'b1) begin
          m_in_frame = 1'b1;
          m_pos = 0;
        end
      end else begin
        m_pos++;
        m_bits[m_pos] = bus.din;
        if (m_pos == FLEN - 1) begin
          m_in_frame = 1'b0;
          payload = 0;
          par = 1'b0;
          for (int i = 0; i < DW; i++) payload += m_bits[i+1] ? (1 << i) : 0;
          for (int i = 1; i < FLEN - 1; i++) par ^= m_bits[i];
          good = (m_bits[FLEN-1] == 1'b0) && (!HAS_PAR || par == 1'b0);
          if (!good) m_err = 1'b1;
          else if (!m_valid || bus.out_ready) begin
            m_data  = payload[DW-1:0];
            m_valid = 1'b1;
          end else m_over = 1'b1;
        end
      end
      if (!good && consume) m_valid = 1'b0;
      m_busy = m_in_frame;
    end
  endtask

  task automatic step();
    @(posedge clkAB);
    model_update();
    #1;
    chk("model_valid", bus.out_valid, m_valid);
    chk("model_data",  bus.out_data,  m_data);
    chk("model_err",   bus.frame_err, m_err);
    chk("model_over",  bus.overrun,   m_over);
    chk("model_busy",  bus.busy,      m_busy);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.din = IDLE_LEVEL; bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] p, input logic stop, input logic rdy_end,
                            input logic bad_par, input bit rnd_rdy);
    logic bits [$];
    bits.push_back(1'b1);
    for (int i = 0; i < DW; i++) bits.push_back(p[i]);
    if (HAS_PAR) bits.push_back((^p) ^ bad_par);
    bits.push_back(stop);
    foreach (bits[i]) begin
      bus.din = bits[i];
      bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : ((i == bits.size() - 1) ? rdy_end : 1'b0);
      step();
      if (bus.out_valid && first_valid < 0) first_valid = i + 1;
    end
    bus.din = IDLE_LEVEL;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h77, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8'hF0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h0F, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
    first_valid = -1;

    rst = 1'b1; bus.din = IDLE_LEVEL; bus.out_ready = 1'b0;
    step(); step();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data",  bus.out_data,  8'h00);
    chk("rst_err",   bus.frame_err, 1'b0);
    chk("rst_over",  bus.overrun,   1'b0);
    chk("rst_busy",  bus.busy,      1'b0);
    rst = 1'b0;
    step();

    foreach (vecs[k]) begin
      send_frame(vecs[k].payload, vecs[k].stop, vecs[k].rdy_end, 1'b0, 1'b0);
      chk($sformatf("vec%0d_valid", k), bus.out_valid, vecs[k].e_valid);
      chk($sformatf("vec%0d_data", k),  bus.out_data,  vecs[k].e_data);
      chk($sformatf("vec%0d_err", k),   bus.frame_err, vecs[k].e_err);
      chk($sformatf("vec%0d_over", k),  bus.overrun,   vecs[k].e_over);
    end

    // Latency from start bit to out_valid.
    do_reset();
    first_valid = -1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("latency", first_valid, FLEN);
    chk("lat_data", bus.out_data, 8'hA5);

    // Bad stop bit: one-cycle error pulse, no load, back to idle.
    do_reset();
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stoperr_pulse", bus.frame_err, 1'b1);
    chk("stoperr_valid", bus.out_valid, 1'b0);
    chk("stoperr_busy",  bus.busy,      1'b0);
    step();
    chk("stoperr_end",   bus.frame_err, 1'b0);

    // Overrun: second frame dropped, later handshake drains the first.
    do_reset();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_data", bus.out_data, 8'h11);
    chk("ovr_flag", bus.overrun,  1'b1);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    chk("ovr_drain_valid", bus.out_valid, 1'b0);
    step();
    chk("ovr_sticky", bus.overrun, 1'b1);

    // Back-to-back frames with handshake on the second completion.
    do_reset();
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_first", bus.out_data, 8'h12);
    send_frame(8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("b2b_data",  bus.out_data, 8'h34);
    chk("b2b_valid", bus.out_valid, 1'b1);
    chk("b2b_over",  bus.overrun,  1'b0);

    // Reset in the middle of a frame.
    do_reset();
    send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.din = 1'b1; step();
    for (int i = 0; i < 4; i++) begin bus.din = i[0]; step(); end
    rst = 1'b1; step();
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_data",  bus.out_data,  8'h00);
    chk("midrst_busy",  bus.busy,      1'b0);
    chk("midrst_err",   bus.frame_err, 1'b0);
    rst = 1'b0; bus.din = IDLE_LEVEL; step();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_new", bus.out_data, 8'h5A);
    chk("midrst_newv", bus.out_valid, 1'b1);

`ifdef SERIAL_DEFRAMER_PARITY_EN
    do_reset();
    send_frame(8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_ok_data", bus.out_data, 8'h07);
    chk("par_ok_err",  bus.frame_err, 1'b0);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    send_frame(8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_bad_err",   bus.frame_err, 1'b1);
    chk("par_bad_valid", bus.out_valid, 1'b0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        send_frame(DW'($urandom), ($urandom_range(0, 7) == 0), 1'b0, ($urandom_range(0, 7) == 0), 1'b1);
      end else if (r <= 7) begin
        for (int k = 0; k < $urandom_range(0, 3); k++) begin
          bus.din = IDLE_LEVEL; bus.out_ready = 1'($urandom_range(0, 1)); step();
        end
      end else if (r == 8) begin
        for (int k = 0; k < $urandom_range(1, 6); k++) begin
          bus.din = 1'($urandom_range(0, 1)); bus.out_ready = 1'($urandom_range(0, 1)); step();
        end
      end else begin
        if ($urandom_range(0, 3) == 0) do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
